// File: rtl/fma16_pkg.sv
// Shared constants and the add-stage hand-off record for the fp16 FMA
// add/normalize stage.
package fma16_pkg;

  localparam int NF   = 10;           // fraction bits
  localparam int PW   = 2*NF + 2;     // product significand width
  localparam int AW   = 3*NF + 4;     // aligned addend / sum magnitude width
  localparam int SW   = AW + 1;       // sum width including the sign bit
  localparam int EW   = 7;            // signed internal exponent width
  localparam int BIAS = 15;           // fp16 exponent bias
  localparam int LZW  = $clog2(AW + 1); // leading-zero count width

  // Result of the add/sign/abs step, consumed by normalization.
  // sign is the pre-negation sign (or the exact-zero sign); the final sign
  // is sign ^ neg. base_exp already holds the exponent before the LZC
  // correction.
  typedef struct packed {
    logic          sign;
    logic          neg;
    logic [AW-1:0] mag;
    logic          sticky;
    logic          zero;
    logic [EW-1:0] base_exp;
  } fma_sum_t;

endpackage

// File: rtl/fma_lzc.sv
// Parameterized leading-zero counter. An all-zero input returns AW.
module fma_lzc #(
  parameter int AW = 34,
  parameter int CW = $clog2(AW + 1)
) (
  input  logic [AW-1:0] i_vec,
  output logic [CW-1:0] o_cnt
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    o_cnt = CW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (i_vec[i]) o_cnt = CW'(AW - 1 - i);
    end
  end

endmodule

// File: rtl/fma_add_norm.sv
// FMA add/normalize stage: adds the product significand to the aligned
// addend, resolves sign, normalizes and passes sticky on to the rounder.
// Configuration macro FMA_ADD_NORM_PIPE2_EN:
//   defined   -> two register stages (add | normalize), latency 2
//   undefined -> one register stage after normalize, latency 1
module fma_add_norm
  import fma16_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          Xs,
  input  logic          Ys,
  input  logic          Zs,
  input  logic [4:0]    Xe,
  input  logic [4:0]    Ye,
  input  logic [4:0]    Ze,
  input  logic [PW-1:0] Pm,
  input  logic [AW-1:0] Am,
  input  logic          ASticky,
  input  logic          KillProd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] Mm,
  output logic [EW-1:0] Me,
  output logic          Ms,
  output logic          MSticky,
  output logic          MZero
);

  logic [EW-1:0]  w_pe;
  logic           w_inv_a;
  logic           w_cin;
  logic [SW-1:0]  w_p_ext;
  logic [SW-1:0]  w_a_ext;
  logic [SW-1:0]  w_sum;
  logic           w_neg;
  logic [AW-1:0]  w_mag;
  logic           w_zero;
  fma_sum_t       w_s1;
  fma_sum_t       w_s2_in;
  logic [LZW-1:0] w_lzc;
  logic [AW-1:0]  w_mm;
  logic [EW-1:0]  w_me;
  logic           w_up_v;
  logic           w_out_en;
  logic           w_load;

  logic           r_out_v;
  logic [AW-1:0]  r_mm;
  logic [EW-1:0]  r_me;
  logic           r_ms;
  logic           r_msticky;
  logic           r_mzero;

  // Product exponent and the two operands placed on the common sum grid.
  assign w_pe    = EW'(Xe) + EW'(Ye) - EW'(BIAS);
  assign w_inv_a = Xs ^ Ys ^ Zs;
  // With sticky set the addend carries a hidden fraction, so the +1 of the
  // two's complement is dropped (one's complement is the truncated result).
  assign w_cin   = w_inv_a & ~ASticky;
  assign w_p_ext = {1'b0, {NF{1'b0}}, Pm, 2'b00};
  assign w_a_ext = {1'b0, Am};
  assign w_sum   = KillProd ? w_a_ext
                            : (w_p_ext + (w_inv_a ? ~w_a_ext : w_a_ext) + SW'(w_cin));
  assign w_neg   = w_sum[AW];
  assign w_mag   = w_neg ? (~w_sum[AW-1:0] + AW'(1)) : w_sum[AW-1:0];
  assign w_zero  = (w_mag == '0) & ~ASticky;

  // Pack the add/sign/abs result; an exact zero takes the round-to-nearest
  // sign (+0 unless both terms are negative).
  always_comb begin
    w_s1          = '0;
    w_s1.sign     = w_zero ? ((Xs ^ Ys) & Zs) : (KillProd ? Zs : (Xs ^ Ys));
    w_s1.neg      = w_neg;
    w_s1.mag      = w_mag;
    w_s1.sticky   = ASticky;
    w_s1.zero     = w_zero;
    w_s1.base_exp = KillProd ? (EW'(Ze) + EW'(12)) : (w_pe + EW'(11));
  end

  fma_lzc #(.AW(AW), .CW(LZW)) u_lzc (
    .i_vec (w_s2_in.mag),
    .o_cnt (w_lzc)
  );

  assign w_mm     = w_s2_in.mag << w_lzc;
  assign w_me     = w_s2_in.zero ? '0 : (w_s2_in.base_exp - EW'(w_lzc));
  assign w_out_en = ~r_out_v | out_ready;
  assign w_load   = w_up_v & w_out_en;

`ifdef FMA_ADD_NORM_PIPE2_EN
  fma_sum_t r_s1;
  logic     r_s1_v;

  assign w_up_v   = r_s1_v;
  assign w_s2_in  = r_s1;
  assign in_ready = ~r_s1_v | w_out_en;

  // Add stage register: fills on accept, empties when it moves downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (in_valid && in_ready) begin
      r_s1_v <= 1'b1;
      r_s1   <= w_s1;
    end else if (w_out_en) begin
      r_s1_v <= 1'b0;
    end
  end
`else
  assign w_up_v   = in_valid;
  assign w_s2_in  = w_s1;
  assign in_ready = w_out_en;
`endif

  // Output register: loads a normalized result whenever it is free or draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_v   <= 1'b0;
      r_mm      <= '0;
      r_me      <= '0;
      r_ms      <= 1'b0;
      r_msticky <= 1'b0;
      r_mzero   <= 1'b0;
    end else begin
      if (w_out_en) r_out_v <= w_up_v;
      if (w_load) begin
        r_mm      <= w_mm;
        r_me      <= w_me;
        r_ms      <= w_s2_in.sign ^ w_s2_in.neg;
        r_msticky <= w_s2_in.sticky;
        r_mzero   <= w_s2_in.zero;
      end
    end
  end

  assign out_valid = r_out_v;
  assign Mm        = r_mm;
  assign Me        = r_me;
  assign Ms        = r_ms;
  assign MSticky   = r_msticky;
  assign MZero     = r_mzero;

endmodule
